uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmit FIFO write port between two requesters (requester 0: CPU path; requester 1: debug/status path).
- Grants one requester at a time and forwards bytes into the FIFO, honouring its full flag.
- Burst-locks the grant until the requester's last byte, a burst limit, or request withdrawal.
- Sits between the byte producers and the UART TX FIFO; the FIFO and transmitter are unchanged.

Parameters:
- DB, 8, data width of one byte/word written to the FIFO.
- MAX_BURST, 16, maximum number of writes per grant (legal 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 has a byte on data0.
- data0  input  DB  requester 0 byte.
- last0  input  1  data0 is the final byte of requester 0's burst.
- ack0  output  1  data0 written this cycle; requester 0 advances on this edge.
- req1  input  1  requester 1 has a byte on data1.
- data1  input  DB  requester 1 byte.
- last1  input  1  data1 is the final byte of requester 1's burst.
- ack1  output  1  data1 written this cycle.
- fifo_full  input  1  FIFO cannot accept a write this cycle.
- fifo_wr  output  1  FIFO write strobe.
- fifo_wdata  output  DB  FIFO write data.
- grant  output  2  one-hot current owner; bit0 is requester 0.
- busy  output  1  arbiter is not in IDLE.

Behaviour:
- Reset (async, rst_n=0), effective immediately:
  - State is IDLE; grant=2'b00; burst count=0; rr pointer favours requester 0.
  - ack0, ack1 and fifo_wr are 0; busy=0.
  - fifo_wdata is don't-care.
- Reset mid-burst: the burst is abandoned with no further write. After release, arbitration restarts from IDLE.
- States: IDLE, XFER, RELEASE. All state, grant, count and pointer registers update on the rising edge of clk.
- IDLE:
  - No request: stay in IDLE.
  - One requester asserting req: grant it.
  - Both asserting req: grant the rr-pointer side.
  - On a grant: load grant, clear burst count, go to XFER.
  - Grant latency is 1 cycle from req sampled to grant visible.
- XFER:
  - ackN = grant[N] & reqN & !fifo_full. This is combinational, with zero latency.
  - fifo_wr = ack0 | ack1.
  - fifo_wdata = data of the granted requester; it is 0 when grant=0.
  - On a write edge, the burst count increments.
  - Go to RELEASE if lastN, or if count+1==MAX_BURST.
  - Stall: fifo_full=1 gives no write, no count change, and the state holds. last during a stall has no effect until the write occurs.
  - Withdrawal: granted req=0 goes to RELEASE with no write.
  - A request from the non-granted requester is ignored until IDLE.
- RELEASE:
  - grant=0; the rr pointer points at the requester that was not just served; go to IDLE.
  - This inserts a mandatory 1-cycle gap between bursts.
  - Minimum turnaround from the last write to the next grant is 2 cycles.
- Only one ack is ever high in a cycle; ack is never high outside XFER.
- busy=1 in XFER and RELEASE.
- Burst count width is clog2(MAX_BURST+1) and never wraps. Reaching MAX_BURST forces release.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: requester 0 wins every IDLE tie; the rr pointer is not implemented. Burst lock and release rules are unchanged.
- Undefined (default): round-robin as described above.

Test Plan:
- Single burst:
  - Stimulus: reset; req0=1 with bytes 0x41,0x42,0x43, last0 on 0x43; fifo_full=0.
  - Response: grant=01 one cycle after req0. fifo_wr high 3 consecutive cycles with fifo_wdata 0x41,0x42,0x43. ack0 pulses align with the writes. grant=00 in the following cycle; busy returns to 0 one cycle later.
- Round-robin:
  - Stimulus: req0 and req1 held high; each sends a 1-byte burst with last=1 (0xA0 from req0, 0xB0 from req1), repeated 4 times.
  - Response: grant sequence 01,10,01,10, with one idle cycle between each.
  - Same stimulus with ARB_FIXED_PRIO_EN: grant=01 every time.
- Backpressure:
  - Stimulus: during a requester 1 burst of 0x10..0x13, fifo_full=1 for 5 cycles after 0x11.
  - Response: fifo_wr=0 and ack1=0 for those 5 cycles. Grant stays 10. Writes resume with 0x12; no byte is lost or duplicated.
- Burst limit:
  - Stimulus: MAX_BURST=4; req0 streams 6 bytes with last0=0.
  - Response: 4 writes, then release. Requester 1, if requesting, is granted next. The remaining 2 bytes are written in a later grant.
- Withdrawal and reset:
  - Stimulus: drop req0 mid-burst.
  - Response: no write that cycle; RELEASE then IDLE.
  - Stimulus: assert rst_n=0 mid-XFER with fifo_full=0.
  - Response: grant=00, ack=0, fifo_wr=0 immediately, without waiting for a clock edge. After reset, the first grant goes to requester 0 on a tie.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Two-requester burst-locked arbiter in front of the UART TX FIFO write port.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module uart_tx_arbiter #(
  parameter int DB        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [DB-1:0] data0,
  input  logic          last0,
  output logic          ack0,
  input  logic          req1,
  input  logic [DB-1:0] data1,
  input  logic          last1,
  output logic          ack1,
  input  logic          fifo_full,
  output logic          fifo_wr,
  output logic [DB-1:0] fifo_wdata,
  output logic [1:0]    grant,
  output logic          busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          in_xfer;
  logic          req_sel;
  logic          last_sel;
  logic          tie1;

`ifdef ARB_FIXED_PRIO_EN
  assign tie1 = 1'b0;
`else
  logic rr_q, rr_d;
  assign tie1 = rr_q;
`endif

  assign in_xfer  = (state_q == XFER);
  assign req_sel  = |(grant_q & {req1, req0});
  assign last_sel = |(grant_q & {last1, last0});
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    ack0    = in_xfer & grant_q[0] & req0 & ~fifo_full;
    ack1    = in_xfer & grant_q[1] & req1 & ~fifo_full;
    fifo_wr = ack0 | ack1;
    grant   = grant_q;
    busy    = (state_q != IDLE);
    unique case (1'b1)
      grant_q[0]: fifo_wdata = data0;
      grant_q[1]: fifo_wdata = data1;
      default:    fifo_wdata = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
`ifndef ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          if (req0 & (~req1 | ~tie1)) begin
            grant_d = 2'b01;
          end else begin
            grant_d = 2'b10;
          end
          cnt_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (!req_sel) begin
          grant_d = 2'b00;
          state_d = RELEASE;
`ifndef ARB_FIXED_PRIO_EN
          rr_d    = grant_q[0];
`endif
        end else if (fifo_wr) begin
          cnt_d = cnt_inc;
          // last byte or burst limit both close the grant
          if (last_sel || cnt_inc == MAXC) begin
            grant_d = 2'b00;
            state_d = RELEASE;
`ifndef ARB_FIXED_PRIO_EN
            rr_d    = grant_q[0];
`endif
          end
        end
      end
      RELEASE: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      cnt_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised + directed bench for uart_tx_arbiter against a queue-based model.
// Honours ARB_FIXED_PRIO_EN when defined for the build.
module tb_uart_tx_arbiter;

  localparam int MAXB = 4;

  logic       clk, rst_n;
  logic       req0, last0, req1, last1, fifo_full;
  logic [7:0] data0, data1;
  logic       ack0, ack1, fifo_wr, busy;
  logic [7:0] fifo_wdata;
  logic [1:0] grant;

  uart_tx_arbiter #(.DB(8), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .data0(data0), .last0(last0), .ack0(ack0),
    .req1(req1), .data1(data1), .last1(last1), .ack1(ack1),
    .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_wdata(fifo_wdata), .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit en0 = 1, en1 = 1, rnd_full = 0;
  int ff_lo = -1, ff_hi = -1;
  bit pop0 = 0, pop1 = 0;

  int m_owner = -1;
  bit m_rel   = 0;
  int m_cnt   = 0;
  int m_pref  = 0;

  logic [1:0] tr_g  [0:8191];
  logic [1:0] tr_a  [0:8191];
  logic       tr_wr [0:8191];
  logic [7:0] tr_wd [0:8191];
  logic       tr_b  [0:8191];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (rst_n) begin
      if (pop0 && q0.size() > 0) q0.delete(0);
      if (pop1 && q1.size() > 0) q1.delete(0);
    end
    req0 = en0 && q0.size() > 0;
    req1 = en1 && q1.size() > 0;
    {last0, data0} = q0.size() > 0 ? q0[0] : 9'h0;
    {last1, data1} = q1.size() > 0 ? q1[0] : 9'h0;
    fifo_full = (cyc >= ff_lo && cyc <= ff_hi) ||
                (rnd_full && $urandom_range(0, 3) == 0);
  end

  always @(negedge clk) begin
    logic [1:0] eg;
    logic       ea0, ea1, eb, r, l, done;
    logic [7:0] ewd;
    if (!rst_n) begin
      m_owner = -1; m_rel = 0; m_cnt = 0; m_pref = 0;
      pop0 = 0; pop1 = 0;
    end else begin
      eg  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      ea0 = (m_owner == 0) && req0 && !fifo_full;
      ea1 = (m_owner == 1) && req1 && !fifo_full;
      ewd = (m_owner == 0) ? data0 : (m_owner == 1) ? data1 : 8'h00;
      eb  = (m_owner >= 0) || m_rel;
      chk("grant", grant, eg);
      chk("ack0", ack0, ea0);
      chk("ack1", ack1, ea1);
      chk("fifo_wr", fifo_wr, ea0 | ea1);
      chk("fifo_wdata", fifo_wdata, ewd);
      chk("busy", busy, eb);
      if (cyc < 8192) begin
        tr_g[cyc] = grant; tr_a[cyc] = {ack1, ack0};
        tr_wr[cyc] = fifo_wr; tr_wd[cyc] = fifo_wdata; tr_b[cyc] = busy;
      end
      pop0 = ea0; pop1 = ea1;
      if (m_rel) begin
        m_rel = 0;
      end else if (m_owner < 0) begin
        if (req0 && req1) m_owner = m_pref;
        else if (req0) m_owner = 0;
        else if (req1) m_owner = 1;
        m_cnt = 0;
      end else begin
        r = (m_owner == 0) ? req0 : req1;
        l = (m_owner == 0) ? last0 : last1;
        done = 0;
        if (!r) done = 1;
        else if (!fifo_full) begin
          m_cnt++;
          if (l || m_cnt == MAXB) done = 1;
        end
        if (done) begin
`ifdef ARB_FIXED_PRIO_EN
          m_pref = 0;
`else
          m_pref = 1 - m_owner;
`endif
          m_owner = -1;
          m_rel   = 1;
        end
      end
    end
  end

  task automatic tchk(input string nm, input int c, input logic [1:0] g,
                      input logic wr, input logic [7:0] wd, input logic b);
    chk({nm, "_g"}, tr_g[c], g);
    chk({nm, "_wr"}, tr_wr[c], wr);
    if (wr) chk({nm, "_wd"}, tr_wd[c], wd);
    chk({nm, "_busy"}, tr_b[c], b);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && m_owner < 0 && !m_rel) begin
        ok = 1;
        break;
      end
    end
    chk("idle_timeout", ok, 1);
    repeat (3) @(negedge clk);
  endtask

  int s;

  initial begin
    rst_n = 0; req0 = 0; req1 = 0; last0 = 0; last1 = 0;
    data0 = 0; data1 = 0; fifo_full = 0;
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_wr", fifo_wr, 0);
    chk("rst_ack", {ack1, ack0}, 2'b00);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #3 rst_n = 1;
    repeat (3) @(negedge clk);

    // single burst
    s = cyc + 1;
    q0.push_back({1'b0, 8'h41});
    q0.push_back({1'b0, 8'h42});
    q0.push_back({1'b1, 8'h43});
    repeat (10) @(negedge clk);
    tchk("sb0", s,     2'b00, 0, 8'h00, 0);
    tchk("sb1", s + 1, 2'b01, 1, 8'h41, 1);
    tchk("sb2", s + 2, 2'b01, 1, 8'h42, 1);
    tchk("sb3", s + 3, 2'b01, 1, 8'h43, 1);
    chk("sb_ack", tr_a[s + 3], 2'b01);
    tchk("sb4", s + 4, 2'b00, 0, 8'h00, 1);
    tchk("sb5", s + 5, 2'b00, 0, 8'h00, 0);
    wait_idle();

    // backpressure on requester 1
    s = cyc + 1;
    ff_lo = s + 3; ff_hi = s + 7;
    q1.push_back({1'b0, 8'h10});
    q1.push_back({1'b0, 8'h11});
    q1.push_back({1'b0, 8'h12});
    q1.push_back({1'b1, 8'h13});
    repeat (14) @(negedge clk);
    tchk("bp1", s + 1, 2'b10, 1, 8'h10, 1);
    tchk("bp2", s + 2, 2'b10, 1, 8'h11, 1);
    for (int k = 3; k <= 7; k++) begin
      tchk("bp_stall", s + k, 2'b10, 0, 8'h00, 1);
      chk("bp_ack1", tr_a[s + k], 2'b00);
    end
    tchk("bp8", s + 8, 2'b10, 1, 8'h12, 1);
    tchk("bp9", s + 9, 2'b10, 1, 8'h13, 1);
    tchk("bp10", s + 10, 2'b00, 0, 8'h00, 1);
    ff_lo = -1; ff_hi = -1;
    wait_idle();

    // burst limit, then withdrawal when the stream runs dry
    s = cyc + 1;
    for (int k = 0; k < 6; k++) q0.push_back({1'b0, 8'(8'h50 + k)});
    q1.push_back({1'b1, 8'hC0});
    repeat (16) @(negedge clk);
    for (int k = 0; k < 4; k++)
      tchk("bl_w", s + 1 + k, 2'b01, 1, 8'(8'h50 + k), 1);
    tchk("bl_rel", s + 5, 2'b00, 0, 8'h00, 1);
    tchk("bl_idle", s + 6, 2'b00, 0, 8'h00, 0);
`ifdef ARB_FIXED_PRIO_EN
    tchk("bl_next", s + 7, 2'b01, 1, 8'h54, 1);
`else
    tchk("bl_next", s + 7, 2'b10, 1, 8'hC0, 1);
    tchk("bl_r4", s + 10, 2'b01, 1, 8'h54, 1);
    tchk("bl_r5", s + 11, 2'b01, 1, 8'h55, 1);
    tchk("wd_nowr", s + 12, 2'b01, 0, 8'h00, 1);
    tchk("wd_rel", s + 13, 2'b00, 0, 8'h00, 1);
    tchk("wd_idle", s + 14, 2'b00, 0, 8'h00, 0);
`endif
    wait_idle();

    // asynchronous reset in the middle of a burst
    for (int k = 0; k < 8; k++) q0.push_back({1'b0, 8'(8'h60 + k)});
    repeat (3) @(negedge clk);
    @(posedge clk); #3 rst_n = 0;
    #1;
    chk("mrst_grant", grant, 2'b00);
    chk("mrst_ack", {ack1, ack0}, 2'b00);
    chk("mrst_wr", fifo_wr, 0);
    chk("mrst_busy", busy, 0);
    q0.delete(); q1.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #3 rst_n = 1;
    repeat (2) @(negedge clk);

    // round-robin on permanent ties
    s = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      q0.push_back({1'b1, 8'hA0});
      q1.push_back({1'b1, 8'hB0});
    end
    repeat (16) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
      tchk("rr_g", s + 1 + 3 * k, 2'b01, 1, 8'hA0, 1);
`else
      tchk("rr_g", s + 1 + 3 * k, (k % 2) ? 2'b10 : 2'b01, 1,
           (k % 2) ? 8'hB0 : 8'hA0, 1);
`endif
      tchk("rr_gap", s + 2 + 3 * k, 2'b00, 0, 8'h00, 1);
      tchk("rr_idle", s + 3 + 3 * k, 2'b00, 0, 8'h00, 0);
    end
    wait_idle();

    // random traffic with stalls, withdrawals and burst limits
    rnd_full = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (q0.size() == 0 && $urandom_range(0, 5) == 0) begin
        int n = $urandom_range(1, 7);
        for (int i = 0; i < n; i++)
          q0.push_back({(i == n - 1) && ($urandom_range(0, 3) != 0),
                        8'($urandom)});
      end
      if (q1.size() == 0 && $urandom_range(0, 5) == 0) begin
        int n = $urandom_range(1, 7);
        for (int i = 0; i < n; i++)
          q1.push_back({(i == n - 1) && ($urandom_range(0, 3) != 0),
                        8'($urandom)});
      end
      en0 = $urandom_range(0, 15) != 0;
      en1 = $urandom_range(0, 15) != 0;
    end
    en0 = 1; en1 = 1; rnd_full = 0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
